// File: rtl/apb_bridge_pkg.sv
// rtl/apb_bridge_pkg.sv - shared state encoding, response codes and defaults for the AXI4-Lite to APB bridge
// No ports. Imported by axi_lite_apb_bridge and apb_timeout_counter.
package apb_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int DEFAULT_TIMEOUT_CYCLES = 1024;

endpackage

// File: rtl/apb_timeout_counter.sv
// rtl/apb_timeout_counter.sv - counts APB ACCESS cycles spent without pready
// Ports:
//   clock, reset (async, active-high)
//   clear   in  : zero the count (driven while the transfer is in SETUP)
//   enable  in  : an ACCESS cycle passed without pready
//   expired out : this missed-pready cycle brings the count to LIMIT
// Instantiated only when APB_BRIDGE_TIMEOUT_EN is defined.
module apb_timeout_counter
  import apb_bridge_pkg::*;
#(
  parameter int LIMIT = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [15:0] LAST = 16'(LIMIT - 1);

  logic [15:0] count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 16'd1;
    end
  end

  // Gated by enable so a pready in the same cycle always beats the timeout.
  assign expired = enable && (count == LAST);

endmodule

// File: rtl/axi_lite_apb_bridge.sv
// rtl/axi_lite_apb_bridge.sv - AXI4-Lite slave to APB master bridge, one transfer outstanding
// Ports:
//   clock, reset (async, active-high)
//   aw*/w*/b*  : AXI write address, data and response channels
//   ar*/r*     : AXI read address and data channels
//   p* outputs : registered APB request (paddr, psel, penable, pprot, pwrite, pwdata, pstrb)
//   pready, prdata, pslverr : APB completion
// Optional feature: APB_BRIDGE_TIMEOUT_EN aborts an ACCESS phase after TIMEOUT_CYCLES
// cycles without pready; when undefined, TIMEOUT_CYCLES is accepted but unused.
module axi_lite_apb_bridge
  import apb_bridge_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] awaddr,
  input  logic [2:0]  awprot,
  input  logic        wvalid,
  output logic        wready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  output logic        bvalid,
  input  logic        bready,
  output logic [1:0]  bresp,
  input  logic        arvalid,
  output logic        arready,
  input  logic [31:0] araddr,
  input  logic [2:0]  arprot,
  output logic        rvalid,
  input  logic        rready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic [31:0] paddr,
  output logic        psel,
  output logic        penable,
  output logic [2:0]  pprot,
  output logic        pwrite,
  output logic [31:0] pwdata,
  output logic [3:0]  pstrb,
  input  logic        pready,
  input  logic [31:0] prdata,
  input  logic        pslverr
);

  state_t state, state_next;

  logic        aw_held, w_held, ar_held;
  logic [31:0] aw_addr_q, w_data_q, ar_addr_q;
  logic [2:0]  aw_prot_q, ar_prot_q;
  logic [3:0]  w_strb_q;
  logic        last_was_write;
  logic        cur_write;

  logic        aw_hs, w_hs, ar_hs;
  logic        write_ok, read_ok;
  logic        start_write, start_read;
  logic        timed_out, access_done, resp_hs;
  logic [1:0]  resp_code;
  logic [31:0] sel_awaddr, sel_wdata, sel_araddr;
  logic [2:0]  sel_awprot, sel_arprot;
  logic [3:0]  sel_wstrb;

  // Readys are held low while reset is asserted so every output reads 0 in reset.
  assign awready = (state == IDLE) && !aw_held && !reset;
  assign wready  = (state == IDLE) && !w_held  && !reset;
  assign arready = (state == IDLE) && !ar_held && !reset;

  assign aw_hs = awvalid && awready;
  assign w_hs  = wvalid  && wready;
  assign ar_hs = arvalid && arready;

  // A channel accepted this cycle counts as held, so a transfer can start in the
  // handshake cycle; its payload then comes straight from the bus.
  assign write_ok = (aw_held || aw_hs) && (w_held || w_hs);
  assign read_ok  = ar_held || ar_hs;

  assign sel_awaddr = aw_held ? aw_addr_q : awaddr;
  assign sel_awprot = aw_held ? aw_prot_q : awprot;
  assign sel_wdata  = w_held  ? w_data_q  : wdata;
  assign sel_wstrb  = w_held  ? w_strb_q  : wstrb;
  assign sel_araddr = ar_held ? ar_addr_q : araddr;
  assign sel_arprot = ar_held ? ar_prot_q : arprot;

`ifdef APB_BRIDGE_TIMEOUT_EN
  logic tmo_expired;

  apb_timeout_counter #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_timeout (
    .clock  (clock),
    .reset  (reset),
    .clear  (state == SETUP),
    .enable ((state == ACCESS) && !pready),
    .expired(tmo_expired)
  );

  assign timed_out = tmo_expired;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign timed_out      = 1'b0;
`endif

  assign access_done = pready || timed_out;
  assign resp_code   = (pready && !pslverr) ? RESP_OKAY : RESP_SLVERR;
  assign resp_hs     = cur_write ? (bvalid && bready) : (rvalid && rready);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next  = state;
    start_write = 1'b0;
    start_read  = 1'b0;
    case (state)
      IDLE: begin
        // With both eligible, take whichever type did not go last.
        if (write_ok && (!read_ok || !last_was_write)) begin
          start_write = 1'b1;
        end else if (read_ok) begin
          start_read = 1'b1;
        end
        if (start_write || start_read) begin
          state_next = SETUP;
        end
      end
      SETUP:   state_next = ACCESS;
      ACCESS:  if (access_done) state_next = RESP;
      RESP:    if (resp_hs) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      aw_held        <= 1'b0;
      w_held         <= 1'b0;
      ar_held        <= 1'b0;
      aw_addr_q      <= '0;
      aw_prot_q      <= '0;
      w_data_q       <= '0;
      w_strb_q       <= '0;
      ar_addr_q      <= '0;
      ar_prot_q      <= '0;
      last_was_write <= 1'b0;
      cur_write      <= 1'b0;
      paddr          <= '0;
      psel           <= 1'b0;
      penable        <= 1'b0;
      pprot          <= '0;
      pwrite         <= 1'b0;
      pwdata         <= '0;
      pstrb          <= '0;
      bvalid         <= 1'b0;
      bresp          <= '0;
      rvalid         <= 1'b0;
      rresp          <= '0;
      rdata          <= '0;
    end else begin
      if (aw_hs) begin
        aw_held   <= 1'b1;
        aw_addr_q <= awaddr;
        aw_prot_q <= awprot;
      end
      if (w_hs) begin
        w_held   <= 1'b1;
        w_data_q <= wdata;
        w_strb_q <= wstrb;
      end
      if (ar_hs) begin
        ar_held   <= 1'b1;
        ar_addr_q <= araddr;
        ar_prot_q <= arprot;
      end

      if (start_write) begin
        cur_write      <= 1'b1;
        last_was_write <= 1'b1;
        paddr          <= sel_awaddr;
        pprot          <= sel_awprot;
        pwrite         <= 1'b1;
        pwdata         <= sel_wdata;
        pstrb          <= sel_wstrb;
        psel           <= 1'b1;
        penable        <= 1'b0;
      end else if (start_read) begin
        cur_write      <= 1'b0;
        last_was_write <= 1'b0;
        paddr          <= sel_araddr;
        pprot          <= sel_arprot;
        pwrite         <= 1'b0;
        pwdata         <= '0;
        pstrb          <= '0;
        psel           <= 1'b1;
        penable        <= 1'b0;
      end

      if (state == SETUP) begin
        penable <= 1'b1;
      end

      if ((state == ACCESS) && access_done) begin
        psel    <= 1'b0;
        penable <= 1'b0;
        if (cur_write) begin
          bvalid <= 1'b1;
          bresp  <= resp_code;
        end else begin
          rvalid <= 1'b1;
          rresp  <= resp_code;
          rdata  <= pready ? prdata : '0;
        end
      end

      if ((state == RESP) && resp_hs) begin
        if (cur_write) begin
          bvalid  <= 1'b0;
          aw_held <= 1'b0;
          w_held  <= 1'b0;
        end else begin
          rvalid  <= 1'b0;
          ar_held <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_axi_lite_apb_bridge.sv
// tb/tb_axi_lite_apb_bridge.sv - directed and randomized checks of axi_lite_apb_bridge against a transaction-level model
`timescale 1ns/1ps
module tb_axi_lite_apb_bridge;

  localparam int TMO = 8;

  logic        clock = 1'b0;
  logic        reset;
  logic        awvalid, awready;
  logic [31:0] awaddr;
  logic [2:0]  awprot;
  logic        wvalid, wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        bvalid, bready;
  logic [1:0]  bresp;
  logic        arvalid, arready;
  logic [31:0] araddr;
  logic [2:0]  arprot;
  logic        rvalid, rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic [31:0] paddr;
  logic        psel, penable;
  logic [2:0]  pprot;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic        pready;
  logic [31:0] prdata;
  logic        pslverr;

  always #5 clock = ~clock;

  axi_lite_apb_bridge #(.TIMEOUT_CYCLES(TMO)) dut (
    .clock(clock), .reset(reset),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awprot(awprot),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arprot(arprot),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
    .paddr(paddr), .psel(psel), .penable(penable), .pprot(pprot),
    .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb),
    .pready(pready), .prdata(prdata), .pslverr(pslverr)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Transaction-level model: pending requests per channel plus the one
  // transfer in flight and the phase it is in.
  typedef enum int {PH_IDLE, PH_SETUP, PH_ACCESS, PH_RESP} phase_t;

  bit          m_aw, m_w, m_ar, m_lww;
  logic [31:0] m_awaddr, m_wdata, m_araddr;
  logic [2:0]  m_awprot, m_arprot;
  logic [3:0]  m_wstrb;
  phase_t      m_ph;
  int          m_acc;
  bit          t_wr;
  logic [31:0] t_addr, t_wdata, t_rdata;
  logic [2:0]  t_prot;
  logic [3:0]  t_strb;
  logic [1:0]  t_resp;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_aw = 0; m_w = 0; m_ar = 0; m_lww = 0;
    m_awaddr = '0; m_wdata = '0; m_araddr = '0;
    m_awprot = '0; m_arprot = '0; m_wstrb = '0;
    m_ph = PH_IDLE; m_acc = 0;
    t_wr = 0; t_addr = '0; t_wdata = '0; t_rdata = '0;
    t_prot = '0; t_strb = '0; t_resp = '0;
  endtask

  task automatic clear_inputs();
    awvalid = 0; awaddr = '0; awprot = '0;
    wvalid = 0; wdata = '0; wstrb = '0;
    arvalid = 0; araddr = '0; arprot = '0;
    bready = 0; rready = 0;
    pready = 0; prdata = '0; pslverr = 0;
  endtask

  // One clock cycle: compare the DUT against the model, advance the model
  // with this cycle's inputs, cross the edge, drop any accepted valids.
  task automatic step();
    bit ex_awr, ex_wr, ex_arr, ex_sel, ex_bv, ex_rv;
    bit aw_hs, w_hs, ar_hs;
    ex_awr = (m_ph == PH_IDLE) && !m_aw;
    ex_wr  = (m_ph == PH_IDLE) && !m_w;
    ex_arr = (m_ph == PH_IDLE) && !m_ar;
    ex_sel = (m_ph == PH_SETUP) || (m_ph == PH_ACCESS);
    ex_bv  = (m_ph == PH_RESP) && t_wr;
    ex_rv  = (m_ph == PH_RESP) && !t_wr;
    chk1("awready", awready, ex_awr);
    chk1("wready", wready, ex_wr);
    chk1("arready", arready, ex_arr);
    chk1("psel", psel, ex_sel);
    chk1("penable", penable, m_ph == PH_ACCESS);
    if (ex_sel) begin
      chk("paddr", paddr, t_addr);
      chk("pprot", 32'(pprot), 32'(t_prot));
      chk1("pwrite", pwrite, t_wr);
      chk("pstrb", 32'(pstrb), t_wr ? 32'(t_strb) : 32'd0);
      if (t_wr) chk("pwdata", pwdata, t_wdata);
    end
    chk1("bvalid", bvalid, ex_bv);
    chk1("rvalid", rvalid, ex_rv);
    if (ex_bv) chk("bresp", 32'(bresp), 32'(t_resp));
    if (ex_rv) begin
      chk("rresp", 32'(rresp), 32'(t_resp));
      chk("rdata", rdata, t_rdata);
    end

    aw_hs = awvalid && ex_awr;
    w_hs  = wvalid && ex_wr;
    ar_hs = arvalid && ex_arr;
    if (aw_hs) begin m_aw = 1; m_awaddr = awaddr; m_awprot = awprot; end
    if (w_hs)  begin m_w = 1;  m_wdata = wdata;   m_wstrb = wstrb;   end
    if (ar_hs) begin m_ar = 1; m_araddr = araddr; m_arprot = arprot; end
    case (m_ph)
      PH_IDLE: begin
        if (m_aw && m_w && (!m_ar || !m_lww)) begin
          t_wr = 1; t_addr = m_awaddr; t_prot = m_awprot;
          t_wdata = m_wdata; t_strb = m_wstrb; m_lww = 1; m_ph = PH_SETUP;
        end else if (m_ar) begin
          t_wr = 0; t_addr = m_araddr; t_prot = m_arprot;
          t_strb = '0; m_lww = 0; m_ph = PH_SETUP;
        end
      end
      PH_SETUP: begin m_ph = PH_ACCESS; m_acc = 0; end
      PH_ACCESS: begin
        if (pready) begin
          t_resp = pslverr ? 2'b10 : 2'b00;
          if (!t_wr) t_rdata = prdata;
          m_ph = PH_RESP;
        end else begin
          m_acc++;
`ifdef APB_BRIDGE_TIMEOUT_EN
          if (m_acc == TMO) begin
            t_resp = 2'b10;
            if (!t_wr) t_rdata = '0;
            m_ph = PH_RESP;
          end
`endif
        end
      end
      PH_RESP: begin
        if (t_wr ? bready : rready) begin
          if (t_wr) begin m_aw = 0; m_w = 0; end
          else m_ar = 0;
          m_ph = PH_IDLE;
        end
      end
      default: m_ph = PH_IDLE;
    endcase

    @(posedge clock);
    #1;
    if (aw_hs) awvalid = 0;
    if (w_hs)  wvalid = 0;
    if (ar_hs) arvalid = 0;
  endtask

  task automatic check_all_zero(input string tag);
    chk1({tag, "_awready"}, awready, 1'b0);
    chk1({tag, "_wready"}, wready, 1'b0);
    chk1({tag, "_arready"}, arready, 1'b0);
    chk1({tag, "_bvalid"}, bvalid, 1'b0);
    chk1({tag, "_rvalid"}, rvalid, 1'b0);
    chk1({tag, "_psel"}, psel, 1'b0);
    chk1({tag, "_penable"}, penable, 1'b0);
    chk1({tag, "_pwrite"}, pwrite, 1'b0);
    chk({tag, "_paddr"}, paddr, 32'd0);
    chk({tag, "_pwdata"}, pwdata, 32'd0);
    chk({tag, "_rdata"}, rdata, 32'd0);
    chk({tag, "_pstrb"}, 32'(pstrb), 32'd0);
    chk({tag, "_pprot"}, 32'(pprot), 32'd0);
    chk({tag, "_bresp"}, 32'(bresp), 32'd0);
    chk({tag, "_rresp"}, 32'(rresp), 32'd0);
  endtask

  // Asserts reset mid-cycle so the asynchronous clear is visible before any edge.
  task automatic do_reset(input string tag);
    clear_inputs();
    reset = 1;
    #1;
    check_all_zero(tag);
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    reset = 0;
    #1;
    chk1({tag, "_awready_after"}, awready, 1'b1);
  endtask

  // Called in the SETUP cycle; completes the transfer with an OKAY response.
  task automatic serve(input bit wr);
    step();
    pready = 1; prdata = $urandom; pslverr = 0;
    step();
    pready = 0;
    if (wr) bready = 1; else rready = 1;
    step();
    bready = 0; rready = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1);
  end

  initial begin
    int cnt;
    clear_inputs();
    reset = 1;
    #3;
    do_reset("rst");

    // Write with AW and W together.
    awvalid = 1; awaddr = 32'h1000_0004; awprot = 3'b010;
    wvalid = 1; wdata = 32'hDEAD_BEEF; wstrb = 4'b0011;
    step();
    chk1("a_psel", psel, 1'b1);
    chk1("a_penable", penable, 1'b0);
    chk1("a_pwrite", pwrite, 1'b1);
    chk("a_pstrb", 32'(pstrb), 32'h3);
    chk("a_paddr", paddr, 32'h1000_0004);
    chk("a_pwdata", pwdata, 32'hDEAD_BEEF);
    step();
    chk1("a_penable_access", penable, 1'b1);
    pready = 1; prdata = 32'h5555_AAAA; pslverr = 0;
    step();
    pready = 0;
    chk1("a_bvalid", bvalid, 1'b1);
    chk("a_bresp", 32'(bresp), 32'd0);
    bready = 1;
    step();
    bready = 0;
    chk1("a_bvalid_done", bvalid, 1'b0);

    // W first, AW four cycles later.
    wvalid = 1; wdata = 32'h0BAD_F00D; wstrb = 4'hF;
    step();
    for (int i = 0; i < 3; i++) begin
      chk1("b_psel_wait", psel, 1'b0);
      step();
    end
    chk1("b_psel_wait", psel, 1'b0);
    awvalid = 1; awaddr = 32'h2000_0010; awprot = 3'b001;
    step();
    chk1("b_psel_start", psel, 1'b1);
    chk("b_pwdata", pwdata, 32'h0BAD_F00D);
    serve(1);

    // Read with five wait states.
    arvalid = 1; araddr = 32'h1000_0008; arprot = 3'b000;
    step();
    chk("c_paddr_setup", paddr, 32'h1000_0008);
    step();
    for (int i = 0; i < 5; i++) begin
      chk("c_paddr_wait", paddr, 32'h1000_0008);
      chk1("c_penable_wait", penable, 1'b1);
      step();
    end
    chk("c_paddr_last", paddr, 32'h1000_0008);
    pready = 1; prdata = 32'h1234_5678;
    step();
    pready = 0;
    chk1("c_rvalid", rvalid, 1'b1);
    chk("c_rdata", rdata, 32'h1234_5678);
    chk("c_rresp", 32'(rresp), 32'd0);
    rready = 1;
    step();
    rready = 0;

    // Alternation from reset: write first, then read, twice.
    do_reset("alt");
    for (int r = 0; r < 2; r++) begin
      awvalid = 1; awaddr = 32'h3000_0000 + 32'(r); awprot = 3'b000;
      wvalid = 1; wdata = $urandom; wstrb = 4'hC;
      arvalid = 1; araddr = 32'h4000_0000 + 32'(r); arprot = 3'b100;
      step();
      chk1("d_first_write", pwrite, 1'b1);
      serve(1);
      step();
      chk1("d_second_read", pwrite, 1'b0);
      chk("d_read_addr", paddr, 32'h4000_0000 + 32'(r));
      serve(0);
    end

    // Slave error on a write with response backpressure.
    awvalid = 1; awaddr = 32'h5000_0000; wvalid = 1; wdata = 32'h1; wstrb = 4'h1;
    step();
    step();
    pready = 1; pslverr = 1;
    step();
    pready = 0; pslverr = 0;
    awvalid = 1; awaddr = 32'h5000_0004;
    for (int i = 0; i < 3; i++) begin
      chk1("e_bvalid", bvalid, 1'b1);
      chk("e_bresp", 32'(bresp), 32'h2);
      chk1("e_awready", awready, 1'b0);
      step();
    end
    chk("e_bresp_last", 32'(bresp), 32'h2);
    bready = 1;
    step();
    bready = 0;
    wvalid = 1; wdata = 32'h2; wstrb = 4'h2;
    step();
    chk("e_next_addr", paddr, 32'h5000_0004);
    serve(1);

`ifdef APB_BRIDGE_TIMEOUT_EN
    // pready never arrives: abort after TMO ACCESS cycles.
    arvalid = 1; araddr = 32'h6000_0000;
    step();
    cnt = 0;
    for (int i = 0; i < 40 && !rvalid; i++) begin
      if (penable) cnt++;
      step();
    end
    chk("f_access_cycles", 32'(cnt), 32'(TMO));
    chk1("f_rvalid", rvalid, 1'b1);
    chk1("f_psel", psel, 1'b0);
    chk("f_rresp", 32'(rresp), 32'h2);
    chk("f_rdata", rdata, 32'd0);
    rready = 1;
    step();
    rready = 0;

    // pready in the very cycle the timeout would fire wins.
    arvalid = 1; araddr = 32'h6000_0004;
    step();
    step();
    repeat (TMO - 1) step();
    pready = 1; prdata = 32'hCAFE_F00D;
    step();
    pready = 0;
    chk1("g_rvalid", rvalid, 1'b1);
    chk("g_rresp", 32'(rresp), 32'd0);
    chk("g_rdata", rdata, 32'hCAFE_F00D);
    rready = 1;
    step();
    rready = 0;
`endif

    // Reset in the middle of ACCESS.
    arvalid = 1; araddr = 32'h7000_0000;
    step();
    step();
    chk1("h_in_access", penable, 1'b1);
    do_reset("h");
    step();
    chk1("h_no_rvalid", rvalid, 1'b0);

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      if (!awvalid && $urandom_range(0, 3) == 0) begin
        awvalid = 1; awaddr = $urandom; awprot = 3'($urandom);
      end
      if (!wvalid && $urandom_range(0, 3) == 0) begin
        wvalid = 1; wdata = $urandom; wstrb = 4'($urandom);
      end
      if (!arvalid && $urandom_range(0, 3) == 0) begin
        arvalid = 1; araddr = $urandom; arprot = 3'($urandom);
      end
      bready  = ($urandom_range(0, 2) != 0);
      rready  = ($urandom_range(0, 2) != 0);
      pready  = ($urandom_range(0, 2) == 0);
      prdata  = $urandom;
      pslverr = ($urandom_range(0, 4) == 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/axi_lite_apb_bridge.md
# axi_lite_apb_bridge

- Converts AXI4-Lite slave transactions from the core's uncached MMIO path into APB master transfers.
- Sits directly upstream of the APB delayer and drives its `in_*` side.
- One transfer is outstanding at a time.
- When a read and a write are both pending, they are served in strict alternation.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 1024: maximum number of ACCESS cycles spent waiting for `pready` before the transfer is aborted. Used only when `APB_BRIDGE_TIMEOUT_EN` is defined.

Ports (clock `clock`, single domain; reset `reset` is asynchronous, active-high):
- `clock` in 1: the only clock.
- `reset` in 1: asynchronous, active-high.
- `awvalid` in 1, `awready` out 1, `awaddr` in 32, `awprot` in 3: AXI write-address channel.
- `wvalid` in 1, `wready` out 1, `wdata` in 32, `wstrb` in 4: AXI write-data channel.
- `bvalid` out 1, `bready` in 1, `bresp` out 2: AXI write-response channel.
- `arvalid` in 1, `arready` out 1, `araddr` in 32, `arprot` in 3: AXI read-address channel.
- `rvalid` out 1, `rready` in 1, `rdata` out 32, `rresp` out 2: AXI read-data channel.
- `paddr` out 32, `psel` out 1, `penable` out 1, `pprot` out 3, `pwrite` out 1, `pwdata` out 32, `pstrb` out 4: APB request, all registered.
- `pready` in 1, `prdata` in 32, `pslverr` in 1: APB completion.

## Operation
- Holding registers:
  - `aw_held`, `w_held` and `ar_held` flags.
  - Matching payload registers for each.
  - `last_was_write` flag, reset value 0.
- Readys:
  - `awready = (state==IDLE) & !aw_held`.
  - `wready = (state==IDLE) & !w_held`.
  - `arready = (state==IDLE) & !ar_held`.
  - All are combinational from registered state. Any handshake sets the corresponding held flag.
- A write is eligible when `aw_held & w_held`; a read is eligible when `ar_held`. AW and W may arrive in either order or in the same cycle.
- Arbitration in IDLE:
  - Only one type eligible: start that type.
  - Both eligible: start the write if `last_was_write==0`, otherwise start the read.
  - `last_was_write` is updated when the transfer starts.
- States:
  - IDLE → SETUP: on a start. Load `paddr`, `pprot`, `pwrite`, `pwdata` and `pstrb` (`pstrb=0` for reads); `psel=1`, `penable=0`.
  - SETUP → ACCESS: unconditional; `penable=1`.
  - ACCESS → RESP: on `pready`. Deassert `psel` and `penable`; capture `prdata` (reads only) and `pslverr`.
  - RESP: assert `bvalid` (write) or `rvalid` (read) with resp = `pslverr ? 2'b10 : 2'b00`. On the `bready`/`rready` handshake, clear the served held flags and return to IDLE.
- APB request signals stay stable from SETUP through the ACCESS cycle that sees `pready`.
- Reset values: all valids, readys, `psel`, `penable` and `pwrite` = 0; `paddr`, `pwdata`, `pstrb`, `pprot`, `rdata`, `bresp` and `rresp` = 0; state = IDLE; all held flags = 0.
- Reset asserted mid-transfer returns immediately to the reset values. No response is issued for the aborted transfer.

## Timing
- Handshake at cycle T completes an eligible request:
  - SETUP at T+1.
  - ACCESS at T+2.
  - If `pready=1` at T+2, `bvalid`/`rvalid` rise at T+3.
  - Minimum request-to-response latency is 3 cycles.
- Each cycle `pready` stays low in ACCESS adds one cycle.
- `bvalid`/`rvalid` hold until accepted. The next transfer can start no earlier than the cycle after the response handshake: IDLE takes 1 cycle, then SETUP.
- The response is held indefinitely under `bready`/`rready` backpressure; no new AXI request is accepted meanwhile.
- `pready` seen outside ACCESS is ignored.

## Configuration
- `APB_BRIDGE_TIMEOUT_EN` defined:
  - A 16-bit counter clears on entering ACCESS and increments each ACCESS cycle without `pready`.
  - When the counter reaches `TIMEOUT_CYCLES`, drop `psel`/`penable`, go to RESP with resp 2'b10, and set `rdata=0`.
  - A `pready` arriving in the same cycle as the timeout wins: the transfer completes normally.
- `APB_BRIDGE_TIMEOUT_EN` undefined:
  - No counter; ACCESS waits forever for `pready`.
  - The parameter is accepted but unused.

## Structure
- Shared package `apb_bridge_pkg` holds:
  - the state encoding: IDLE=2'd0, SETUP=2'd1, ACCESS=2'd2, RESP=2'd3;
  - resp constants: `RESP_OKAY=2'b00`, `RESP_SLVERR=2'b10`;
  - the default timeout value.
- The timeout counter is a natural sub-module, `apb_timeout_counter`, instantiated only under the macro.
- Everything else is flat.

## Test plan
- Write with AW and W in the same cycle at T (`awaddr=0x1000_0004`, `wdata=0xDEADBEEF`, `wstrb=4'b0011`), `pready=1` in ACCESS → SETUP at T+1 with `pwrite=1`, `pstrb=0011`; `bvalid`, `bresp=00` at T+3.
- W at T, AW at T+4 → no `psel` before T+5; transfer starts only after both channels are held.
- Read of `0x1000_0008` with `pready` low for 5 ACCESS cycles, then `prdata=0x12345678` → `rvalid` with `rdata=0x12345678` the cycle after `pready`; `paddr` stable throughout.
- Read and write both held in IDLE after reset → write served first, then the read. Repeat the pair → write, read again (alternation).
- `pslverr=1` on a write; `bready` held low 3 cycles → `bresp=10` held stable until the handshake; `awready` stays 0 throughout.
- With `APB_BRIDGE_TIMEOUT_EN`, `TIMEOUT_CYCLES=8`, `pready` never asserted → `psel` drops after 8 ACCESS cycles; `rresp=10`, `rdata=0`. Reset asserted in ACCESS → all outputs return to 0 the same cycle.
